// File: rtl/uart_resp_tx.sv
// uart_resp_tx: serializes an N-byte response word into the UART transmitter,
// MSB byte first, one trmt/tx_done handshake per byte.
// Optional feature: define UART_RESP_CHKSUM_EN to append a two's-complement
// checksum byte after the data bytes.
// Ports:
//   clk, rst      clock, async active-high reset
//   snd_resp      1-cycle strobe to send resp (ignored while busy, sets ovr)
//   resp          response word, latched on acceptance
//   tx_done       transmitter byte-complete level; its rising edge advances
//   clr_ovr       clears the sticky ovr flag
//   trmt          1-cycle start pulse to the transmitter
//   tx_data       byte presented to the transmitter
//   busy          high from acceptance until the response completes
//   resp_sent     1-cycle pulse after the final byte completes
//   ovr           sticky overrun flag
module uart_resp_tx #(
  parameter int NUM_BYTES = 3,
  parameter int TX_GAP    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   snd_resp,
  input  logic [8*NUM_BYTES-1:0] resp,
  input  logic                   tx_done,
  input  logic                   clr_ovr,
  output logic                   trmt,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   resp_sent,
  output logic                   ovr
);

  localparam int unsigned RESP_W = 8 * NUM_BYTES;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned GAP_W  = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(NUM_BYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TX_GAP - 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, GAP, CHK} state_t;

  state_t              state, state_nxt;
  logic [RESP_W-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]    byte_cnt, byte_cnt_nxt;
  logic [GAP_W-1:0]    gap_cnt, gap_cnt_nxt;
  logic                tx_done_q;
  logic                done_edge_q;
  logic                done_edge_c;
  logic                trmt_nxt, busy_nxt, resp_sent_nxt, ovr_nxt;
  logic [7:0]          tx_data_nxt;
`ifdef UART_RESP_CHKSUM_EN
  logic [7:0]          sum, sum_nxt;
`endif

  // Rising edge only; tx_done_q resets high so a level present at reset never counts.
  assign done_edge_c = tx_done & ~tx_done_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    byte_cnt_nxt  = byte_cnt;
    gap_cnt_nxt   = gap_cnt;
    resp_sent_nxt = 1'b0;
    ovr_nxt       = ovr;
    if (clr_ovr)                       ovr_nxt = 1'b0;
    if (snd_resp && (state != IDLE))   ovr_nxt = 1'b1;

    case (state)
      IDLE: begin
        if (snd_resp) begin
          shreg_nxt    = resp;
          byte_cnt_nxt = '0;
          state_nxt    = LOAD;
        end
      end
      LOAD: state_nxt = WAIT;
`ifdef UART_RESP_CHKSUM_EN
      CHK:  state_nxt = WAIT;
`endif
      WAIT: begin
        // The edge is registered, giving the extra cycle of done-to-trmt latency.
        if (done_edge_q) begin
          shreg_nxt    = shreg << 8;
          byte_cnt_nxt = byte_cnt + CNT_W'(1);
          gap_cnt_nxt  = '0;
`ifdef UART_RESP_CHKSUM_EN
          if (byte_cnt == CNT_W'(NUM_BYTES)) begin
            state_nxt     = IDLE;
            resp_sent_nxt = 1'b1;
          end else if (TX_GAP > 0) begin
            state_nxt = GAP;
          end else begin
            state_nxt = (byte_cnt == LAST_DATA) ? CHK : LOAD;
          end
`else
          if (byte_cnt == LAST_DATA) begin
            state_nxt     = IDLE;
            resp_sent_nxt = 1'b1;
          end else if (TX_GAP > 0) begin
            state_nxt = GAP;
          end else begin
            state_nxt = LOAD;
          end
`endif
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
`ifdef UART_RESP_CHKSUM_EN
          state_nxt = (byte_cnt == CNT_W'(NUM_BYTES)) ? CHK : LOAD;
`else
          state_nxt = LOAD;
`endif
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Outputs are registered against the state being entered.
    trmt_nxt    = (state_nxt == LOAD) || (state_nxt == CHK);
    busy_nxt    = (state_nxt != IDLE);
    tx_data_nxt = tx_data;
    if (state_nxt == LOAD) tx_data_nxt = shreg_nxt[RESP_W-1 -: 8];
`ifdef UART_RESP_CHKSUM_EN
    sum_nxt = sum;
    if (state_nxt == LOAD)
      sum_nxt = ((state == IDLE) ? 8'h00 : sum) + shreg_nxt[RESP_W-1 -: 8];
    if (state_nxt == CHK) tx_data_nxt = 8'(8'h00 - sum);
`endif
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      tx_done_q   <= 1'b1;
      done_edge_q <= 1'b0;
      trmt        <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      resp_sent   <= 1'b0;
      ovr         <= 1'b0;
`ifdef UART_RESP_CHKSUM_EN
      sum         <= 8'h00;
`endif
    end else begin
      state       <= state_nxt;
      shreg       <= shreg_nxt;
      byte_cnt    <= byte_cnt_nxt;
      gap_cnt     <= gap_cnt_nxt;
      tx_done_q   <= tx_done;
      done_edge_q <= done_edge_c && (state == WAIT);
      trmt        <= trmt_nxt;
      tx_data     <= tx_data_nxt;
      busy        <= busy_nxt;
      resp_sent   <= resp_sent_nxt;
      ovr         <= ovr_nxt;
`ifdef UART_RESP_CHKSUM_EN
      sum         <= sum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_uart_resp_tx.sv
// tb_uart_resp_tx: directed checks of uart_resp_tx with a 3-byte, no-gap
// instance and a 2-byte instance with TX_GAP=4.
module tb_uart_resp_tx;

`ifdef UART_RESP_CHKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic        clk;
  logic        rst, snd_resp, tx_done, clr_ovr;
  logic [23:0] resp;
  logic        trmt, busy, resp_sent, ovr;
  logic [7:0]  tx_data;

  logic        g_rst, g_snd, g_tx_done, g_clr;
  logic [15:0] g_resp;
  logic        g_trmt, g_busy, g_resp_sent, g_ovr;
  logic [7:0]  g_tx_data;

  int checks = 0;
  int errors = 0;

  uart_resp_tx #(.NUM_BYTES(3), .TX_GAP(0)) u_dut (
    .clk(clk), .rst(rst), .snd_resp(snd_resp), .resp(resp), .tx_done(tx_done),
    .clr_ovr(clr_ovr), .trmt(trmt), .tx_data(tx_data), .busy(busy),
    .resp_sent(resp_sent), .ovr(ovr)
  );

  uart_resp_tx #(.NUM_BYTES(2), .TX_GAP(4)) u_gap (
    .clk(clk), .rst(g_rst), .snd_resp(g_snd), .resp(g_resp), .tx_done(g_tx_done),
    .clr_ovr(g_clr), .trmt(g_trmt), .tx_data(g_tx_data), .busy(g_busy),
    .resp_sent(g_resp_sent), .ovr(g_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // From the cycle after trmt: wait, pulse tx_done, check the follow-up.
  task automatic finish_byte(input logic [7:0] exp, input bit last);
    repeat (5) tick;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk1("trmt_after_done", trmt, 1'b0);
    chk8("tx_data_hold", tx_data, exp);
    tick;
    if (last) begin
      chk1("resp_sent", resp_sent, 1'b1);
      chk1("busy_end", busy, 1'b0);
      chk1("trmt_end", trmt, 1'b0);
      tick;
      chk1("resp_sent_pulse", resp_sent, 1'b0);
    end
  endtask

  // Called in the cycle where trmt for this byte is expected.
  task automatic run_byte(input logic [7:0] exp, input bit last);
    chk1("trmt", trmt, 1'b1);
    chk8("tx_data", tx_data, exp);
    chk1("busy", busy, 1'b1);
    tick;
    chk1("trmt_pulse", trmt, 1'b0);
    finish_byte(exp, last);
  endtask

  task automatic last_byte(input logic [7:0] d, input logic [7:0] c);
    run_byte(d, !CHK_ON);
    if (CHK_ON) run_byte(c, 1'b1);
  endtask

  // Gap instance: tx_done edge at cycle k, next trmt exactly at k+6.
  task automatic g_gap_byte(input logic [7:0] exp);
    repeat (3) tick;
    g_tx_done = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick;
      g_tx_done = 1'b0;
      chk1("gap_trmt", g_trmt, (i == 6));
    end
    chk8("gap_tx_data", g_tx_data, exp);
  endtask

  initial begin
    rst = 1'b1; snd_resp = 1'b0; tx_done = 1'b0; clr_ovr = 1'b0; resp = '0;
    g_rst = 1'b1; g_snd = 1'b0; g_tx_done = 1'b0; g_clr = 1'b0; g_resp = '0;
    tick; tick;
    chk1("rst_trmt", trmt, 1'b0);
    chk8("rst_tx_data", tx_data, 8'h00);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_resp_sent", resp_sent, 1'b0);
    chk1("rst_ovr", ovr, 1'b0);
    rst = 1'b0; g_rst = 1'b0;
    tick;

    // Basic 3-byte response.
    resp = 24'hA55A0F; snd_resp = 1'b1;
    tick;
    snd_resp = 1'b0;
    run_byte(8'hA5, 1'b0);
    run_byte(8'h5A, 1'b0);
    last_byte(8'h0F, 8'hF2);
    chk1("t1_ovr", ovr, 1'b0);
    chk1("t1_busy_after", busy, 1'b0);

    // snd_resp while busy is ignored and sets ovr.
    resp = 24'h123456; snd_resp = 1'b1;
    tick;
    snd_resp = 1'b0;
    chk1("t3_trmt", trmt, 1'b1);
    chk8("t3_tx_data", tx_data, 8'h12);
    tick;
    resp = 24'h111111; snd_resp = 1'b1;
    tick;
    snd_resp = 1'b0;
    chk1("t3_ovr_set", ovr, 1'b1);
    finish_byte(8'h12, 1'b0);
    run_byte(8'h34, 1'b0);
    last_byte(8'h56, 8'h64);
    chk1("t3_ovr_sticky", ovr, 1'b1);
    clr_ovr = 1'b1;
    tick;
    clr_ovr = 1'b0;
    chk1("t3_ovr_clr", ovr, 1'b0);

    // tx_done held high: no advance until it falls and rises again.
    tx_done = 1'b1;
    tick;
    resp = 24'hC33C99; snd_resp = 1'b1;
    tick;
    snd_resp = 1'b0;
    chk1("t4_trmt", trmt, 1'b1);
    chk8("t4_tx_data", tx_data, 8'hC3);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk1("t4_no_advance", trmt, 1'b0);
    end
    chk8("t4_tx_data_held", tx_data, 8'hC3);
    chk1("t4_busy", busy, 1'b1);
    tx_done = 1'b0;
    tick;
    finish_byte(8'hC3, 1'b0);
    run_byte(8'h3C, 1'b0);
    last_byte(8'h99, 8'h68);

    // Reset while waiting on the second byte.
    resp = 24'hDEADBE; snd_resp = 1'b1;
    tick;
    snd_resp = 1'b0;
    run_byte(8'hDE, 1'b0);
    chk1("t5_trmt2", trmt, 1'b1);
    chk8("t5_tx_data2", tx_data, 8'hAD);
    tick; tick;
    rst = 1'b1;
    #2;
    chk1("t5_rst_trmt", trmt, 1'b0);
    chk8("t5_rst_tx_data", tx_data, 8'h00);
    chk1("t5_rst_busy", busy, 1'b0);
    tick; tick;
    rst = 1'b0;
    tx_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      tx_done = 1'b0;
      chk1("t5_idle_trmt", trmt, 1'b0);
      chk1("t5_idle_resp_sent", resp_sent, 1'b0);
    end
    resp = 24'hDEADBE; snd_resp = 1'b1;
    tick;
    snd_resp = 1'b0;
    run_byte(8'hDE, 1'b0);
    run_byte(8'hAD, 1'b0);
    last_byte(8'hBE, 8'hB7);

    // TX_GAP=4 instance, plus acceptance in the resp_sent cycle.
    g_resp = 16'h7E81; g_snd = 1'b1;
    tick;
    g_snd = 1'b0;
    chk1("g_trmt0", g_trmt, 1'b1);
    chk8("g_tx_data0", g_tx_data, 8'h7E);
    g_gap_byte(8'h81);
    if (CHK_ON) g_gap_byte(8'h01);
    repeat (3) tick;
    g_tx_done = 1'b1;
    tick;
    g_tx_done = 1'b0;
    chk1("g_trmt_last", g_trmt, 1'b0);
    tick;
    chk1("g_resp_sent", g_resp_sent, 1'b1);
    chk1("g_busy_low", g_busy, 1'b0);
    g_resp = 16'h1234; g_snd = 1'b1;
    tick;
    g_snd = 1'b0;
    chk1("g_reaccept_trmt", g_trmt, 1'b1);
    chk8("g_reaccept_data", g_tx_data, 8'h12);
    chk1("g_reaccept_ovr", g_ovr, 1'b0);

`ifdef UART_RESP_CHKSUM_EN
    // Checksum of 01+02+03 is FA.
    resp = 24'h010203; snd_resp = 1'b1;
    tick;
    snd_resp = 1'b0;
    run_byte(8'h01, 1'b0);
    run_byte(8'h02, 1'b0);
    run_byte(8'h03, 1'b0);
    run_byte(8'hFA, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
